// File: rtl/mire_gen_if.sv
// Wishbone master write channel used by the test-pattern generator.
interface mire_gen_if #(
    parameter int ADDR_W = 32
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [3:0]        sel;
    logic [2:0]        cti;
    logic [1:0]        bte;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat_ms;
    logic              ack;

    modport master (
        output cyc, stb, we, sel, cti, bte, adr, dat_ms,
        input  ack
    );

    modport slave (
        input  cyc, stb, we, sel, cti, bte, adr, dat_ms,
        output ack
    );
endinterface

// File: rtl/mire_gen.sv
// Test-pattern generator: writes one HDISP x VDISP frame of 0x00RRGGBB pixels
// over Wishbone, in bursts of BURST classic writes separated by a one-cycle gap.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; bus released
// S_BURST | stb high, one pixel write per ack
// S_GAP   | one-cycle release of cyc/stb between bursts
// S_DONE  | frame_done pulse; relaunch if continuous, else back to idle
module mire_gen #(
    parameter int                HDISP     = 800,
    parameter int                VDISP     = 480,
    parameter int                BURST     = 64,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    input  logic [1:0]        mode,
    input  logic [23:0]       fg_color,
    input  logic [23:0]       bg_color,
    output logic              busy,
    output logic              frame_done,
    mire_gen_if.master        wshb
);
    localparam int NPIX     = HDISP * VDISP;
    localparam int PIX_W    = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int X_W      = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int Y_W      = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int BCNT_W   = $clog2(BURST + 1);
    // Bar width in pixels; a narrow display degenerates to one pixel per bar.
    localparam int BAR_PX   = (HDISP / 8 > 0) ? HDISP / 8 : 1;
    localparam int BAR_C_W  = (BAR_PX > 1) ? $clog2(BAR_PX) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [23:0]        fg_q, fg_d;
    logic [23:0]        bg_q, bg_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [BAR_C_W-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]         bar_idx_q, bar_idx_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic [ADDR_W-1:0]  adr_q, adr_d;
    logic               busy_q, busy_d;

    logic               launch;
    logic               acked;
    logic               last_pix;
    logic               burst_last;
    logic               stb_o;
    logic               done_o;
    logic [23:0]        pix_rgb;

    assign launch     = ((state_q == S_IDLE) && start) || ((state_q == S_DONE) && continuous);
    assign acked      = (state_q == S_BURST) && wshb.ack;
    assign last_pix   = (pix_q == PIX_W'(NPIX - 1));
    assign burst_last = (bcnt_q == BCNT_W'(BURST - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_BURST;
            S_BURST: begin
                if (wshb.ack) begin
                    if (last_pix)        state_d = S_DONE;
                    else if (burst_last) state_d = S_GAP;
                end
            end
            S_GAP:   state_d = S_BURST;
            S_DONE:  state_d = continuous ? S_BURST : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs of the FSM.
    always_comb begin
        stb_o  = (state_q == S_BURST);
        done_o = (state_q == S_DONE);
    end

    // Frame counters, address pointer and latched pattern settings.
    always_comb begin
        mode_d    = mode_q;
        fg_d      = fg_q;
        bg_d      = bg_q;
        pix_d     = pix_q;
        x_d       = x_q;
        y_d       = y_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        bcnt_d    = bcnt_q;
        adr_d     = adr_q;
        busy_d    = busy_q;
        if (launch) begin
            mode_d    = mode;
            fg_d      = fg_color;
            bg_d      = bg_color;
            pix_d     = '0;
            x_d       = '0;
            y_d       = '0;
            bar_cnt_d = '0;
            bar_idx_d = '0;
            bcnt_d    = '0;
            adr_d     = BASE_ADDR;
            busy_d    = 1'b1;
        end else if (acked) begin
            pix_d  = pix_q + 1'b1;
            adr_d  = adr_q + ADDR_W'(4);
            bcnt_d = bcnt_q + 1'b1;
            if (x_q == X_W'(HDISP - 1)) begin
                x_d       = '0;
                y_d       = (y_q == Y_W'(VDISP - 1)) ? '0 : y_q + 1'b1;
                bar_cnt_d = '0;
                bar_idx_d = '0;
            end else begin
                x_d = x_q + 1'b1;
                // Bar index saturates at 7 so leftover pixels extend the last bar.
                if (bar_cnt_q == BAR_C_W'(BAR_PX - 1)) begin
                    bar_cnt_d = '0;
                    if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 1'b1;
                end else begin
                    bar_cnt_d = bar_cnt_q + 1'b1;
                end
            end
        end else if (state_q == S_GAP) begin
            bcnt_d = '0;
        end else if (state_q == S_DONE) begin
            adr_d  = BASE_ADDR;
            busy_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q    <= '0;
            fg_q      <= '0;
            bg_q      <= '0;
            pix_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            bcnt_q    <= '0;
            adr_q     <= BASE_ADDR;
            busy_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            fg_q      <= fg_d;
            bg_q      <= bg_d;
            pix_q     <= pix_d;
            x_q       <= x_d;
            y_q       <= y_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            bcnt_q    <= bcnt_d;
            adr_q     <= adr_d;
            busy_q    <= busy_d;
        end
    end

    // Pixel colour for the current (x, y) from the latched pattern settings.
    always_comb begin
        pix_rgb = fg_q;
        case (mode_q)
            2'd0: pix_rgb = fg_q;
            2'd1: pix_rgb = ((x_q & X_W'(3)) == '0) ? fg_q : bg_q;
            2'd2: pix_rgb = (((x_q & X_W'(8)) != '0) ^ ((y_q & Y_W'(8)) != '0)) ? fg_q : bg_q;
            2'd3: begin
                case (bar_idx_q)
                    3'd0:    pix_rgb = 24'hFFFFFF;
                    3'd1:    pix_rgb = 24'hFFFF00;
                    3'd2:    pix_rgb = 24'h00FFFF;
                    3'd3:    pix_rgb = 24'h00FF00;
                    3'd4:    pix_rgb = 24'hFF00FF;
                    3'd5:    pix_rgb = 24'hFF0000;
                    3'd6:    pix_rgb = 24'h0000FF;
                    default: pix_rgb = 24'h000000;
                endcase
            end
            default: pix_rgb = fg_q;
        endcase
    end

    assign wshb.cyc    = stb_o;
    assign wshb.stb    = stb_o;
    assign wshb.we     = 1'b1;
    assign wshb.sel    = 4'b1111;
    assign wshb.cti    = 3'b000;
    assign wshb.bte    = 2'b00;
    assign wshb.adr    = adr_q;
    assign wshb.dat_ms = {8'h00, pix_rgb};
    assign busy        = busy_q;
    assign frame_done  = done_o;
endmodule

// File: tb/tb_mire_gen.sv
module tb_mire_gen;
    localparam int          H     = 16;
    localparam int          V     = 16;
    localparam int          BL    = 12;
    localparam int          NPIX  = H * V;
    localparam int          LASTRUN = (NPIX % BL == 0) ? BL : NPIX % BL;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [23:0] PAL [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        continuous;
    logic [1:0]  mode;
    logic [23:0] fg_color;
    logic [23:0] bg_color;
    logic        busy;
    logic        frame_done;

    mire_gen_if #(.ADDR_W(32)) wshb ();

    mire_gen #(
        .HDISP(H), .VDISP(V), .BURST(BL), .ADDR_W(32), .BASE_ADDR(BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .mode       (mode),
        .fg_color   (fg_color),
        .bg_color   (bg_color),
        .busy       (busy),
        .frame_done (frame_done),
        .wshb       (wshb)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    logic [63:0] sb [$];
    int          wr_cnt = 0;
    int          wr_frame = 0;
    int          done_cnt = 0;
    int          run = 0;
    bit          ack_rand = 1'b0;
    bit          ack_hi = 1'b1;
    bit          cont_phase = 1'b0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [23:0] exp_rgb(int m, logic [23:0] f, logic [23:0] b, int x, int y);
        int bar;
        case (m)
            0: return f;
            1: return (x % 4 == 0) ? f : b;
            2: return (((x / 8) % 2) != ((y / 8) % 2)) ? f : b;
            default: begin
                bar = x / (H / 8);
                if (bar > 7) bar = 7;
                return PAL[bar];
            end
        endcase
    endfunction

    task automatic push_frame(int m, logic [23:0] f, logic [23:0] b);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                sb.push_back({BASE + 32'(4 * (y * H + x)), 8'h00, exp_rgb(m, f, b, x, y)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(int target);
        int n = 0;
        while (done_cnt < target && n < 6000) begin
            tick();
            n++;
        end
        chk("timeout_frame_done", 64'(done_cnt >= target), 64'd1);
    endtask

    task automatic wait_wr(int target);
        int n = 0;
        while (wr_cnt < target && n < 6000) begin
            tick();
            n++;
        end
        chk("timeout_writes", 64'(wr_cnt >= target), 64'd1);
    endtask

    // Slave acknowledge: always high or randomly stalled.
    initial begin
        wshb.ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_rand) wshb.ack = ($urandom_range(0, 2) != 0);
            else          wshb.ack = ack_hi;
        end
    end

    // Bus monitor and scoreboard consumer.
    logic        pend = 1'b0;
    logic [31:0] pend_adr, pend_dat;
    logic        prev_stb = 1'b0, prev_done = 1'b0, prev_lowbusy = 1'b0;
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n !== 1'b1) begin
            run = 0; pend = 1'b0; prev_stb = 1'b0; prev_done = 1'b0;
            prev_lowbusy = 1'b0; wr_frame = 0;
        end else begin
            chk("cyc_eq_stb", 64'(wshb.cyc), 64'(wshb.stb));
            if (pend && wshb.stb) begin
                chk("adr_hold", 64'(wshb.adr), 64'(pend_adr));
                chk("dat_hold", 64'(wshb.dat_ms), 64'(pend_dat));
            end
            if (wshb.stb && wshb.ack) begin
                if (sb.size() == 0) chk("unexpected_write", 64'(wshb.adr), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    e = sb.pop_front();
                    chk("wr_adr", 64'(wshb.adr), 64'(e[63:32]));
                    chk("wr_dat", 64'(wshb.dat_ms), 64'(e[31:0]));
                end
                run++; wr_cnt++; wr_frame++;
                pend = 1'b0;
            end else if (wshb.stb) begin
                pend = 1'b1; pend_adr = wshb.adr; pend_dat = wshb.dat_ms;
            end else pend = 1'b0;
            if (!wshb.stb && prev_stb) begin
                if (frame_done) chk("last_burst_len", 64'(run), 64'(LASTRUN));
                else            chk("burst_len", 64'(run), 64'(BL));
                run = 0;
            end
            if (busy && !wshb.stb && prev_lowbusy) chk("gap_one_cycle", 64'd0, 64'd1);
            if (frame_done) begin
                chk("frame_words", 64'(wr_frame), 64'(NPIX));
                chk("done_busy", 64'(busy), 64'd1);
                chk("done_single_pulse", 64'(prev_done), 64'd0);
                wr_frame = 0;
                done_cnt++;
            end
            if (cont_phase) chk("busy_continuous", 64'(busy), 64'd1);
            prev_stb     = wshb.stb;
            prev_done    = frame_done;
            prev_lowbusy = busy && !wshb.stb;
        end
    end

    initial begin
        int d0, w0;
        rst_n = 1'b0; start = 1'b0; continuous = 1'b0;
        mode = 2'd0; fg_color = 24'h0; bg_color = 24'h0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_stb", 64'(wshb.stb), 64'd0);
        chk("rst_cyc", 64'(wshb.cyc), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        chk("rst_adr", 64'(wshb.adr), 64'(BASE));
        chk("rst_dat", 64'(wshb.dat_ms), 64'd0);
        chk("const_we", 64'(wshb.we), 64'd1);
        chk("const_sel", 64'(wshb.sel), 64'hF);
        chk("const_cti", 64'(wshb.cti), 64'd0);
        chk("const_bte", 64'(wshb.bte), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Solid fill, ack always high.
        mode = 2'd0; fg_color = 24'h123456; bg_color = 24'hABCDEF;
        push_frame(0, 24'h123456, 24'hABCDEF);
        d0 = done_cnt;
        pulse_start();
        mode = 2'd1; fg_color = 24'h0;
        wait_done(d0 + 1);
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_stb", 64'(wshb.stb), 64'd0);
        chk("idle_adr", 64'(wshb.adr), 64'(BASE));
        chk("sb_drained_1", 64'(sb.size()), 64'd0);
        repeat (3) tick();

        // Stripes with random stalls; extra start mid-frame ignored.
        ack_rand = 1'b1;
        mode = 2'd1; fg_color = 24'hFFFFFF; bg_color = 24'h000000;
        push_frame(1, 24'hFFFFFF, 24'h000000);
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        wait_wr(w0 + 30);
        pulse_start();
        wait_done(d0 + 1);
        repeat (3) tick();

        // Colour bars, ack always high.
        ack_rand = 1'b0;
        mode = 2'd3; fg_color = 24'h111111; bg_color = 24'h222222;
        push_frame(3, 24'h111111, 24'h222222);
        d0 = done_cnt;
        pulse_start();
        wait_done(d0 + 1);
        repeat (3) tick();

        // Checkerboard with random stalls.
        ack_rand = 1'b1;
        mode = 2'd2; fg_color = 24'hA5A5A5; bg_color = 24'h5A5A5A;
        push_frame(2, 24'hA5A5A5, 24'h5A5A5A);
        d0 = done_cnt;
        pulse_start();
        wait_done(d0 + 1);
        repeat (3) tick();

        // Continuous: mode changed mid-frame applies only to the next frame.
        mode = 2'd2; fg_color = 24'hA0B0C0; bg_color = 24'h0C0B0A; continuous = 1'b1;
        push_frame(2, 24'hA0B0C0, 24'h0C0B0A);
        push_frame(1, 24'h336699, 24'h996633);
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        cont_phase = 1'b1;
        wait_wr(w0 + 20);
        mode = 2'd1; fg_color = 24'h336699; bg_color = 24'h996633;
        pulse_start();
        wait_done(d0 + 1);
        continuous = 1'b0;
        pulse_start();
        wait_done(d0 + 2);
        cont_phase = 1'b0;
        @(negedge clk);
        chk("cont_end_busy", 64'(busy), 64'd0);
        chk("sb_drained_cont", 64'(sb.size()), 64'd0);
        repeat (3) tick();

        // Reset mid-burst after 5 acks, then a fresh frame from pixel 0.
        ack_rand = 1'b0;
        mode = 2'd0; fg_color = 24'h777777;
        push_frame(0, 24'h777777, 24'h0);
        w0 = wr_cnt;
        pulse_start();
        wait_wr(w0 + 5);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("midrst_stb", 64'(wshb.stb), 64'd0);
        chk("midrst_adr", 64'(wshb.adr), 64'(BASE));
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(frame_done), 64'd0);
        sb.delete();
        rst_n = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("postrst_idle_stb", 64'(wshb.stb), 64'd0);
        tick();
        mode = 2'd3; fg_color = 24'h0;
        push_frame(3, 24'h0, 24'h0);
        d0 = done_cnt;
        pulse_start();
        wait_done(d0 + 1);
        repeat (3) tick();
        chk("sb_drained_final", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mire_gen.md
Name: mire_gen

Overview:
- Parametrised Wishbone test-pattern generator that writes a full HDISP x VDISP frame of 32-bit pixels (0x00RRGGBB) into SDRAM from BASE_ADDR upward.
- Runtime-selectable pattern: solid, stripes, checkerboard or 8 colour bars.
- Configurable burst length.
- Single-shot or continuous frame mode, with busy/frame_done status for the display pipeline.

Parameters:
- HDISP, 800, active pixels per line.
- VDISP, 480, active lines per frame.
- BURST, 64, Wishbone writes per burst before a one-cycle release of cyc/stb (1..HDISP*VDISP).
- ADDR_W, 32, Wishbone address width.
- BASE_ADDR, 0, byte address of pixel (0,0); multiple of 4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to generate one frame; ignored while busy.
- continuous  in  1  when 1 at frame end, next frame starts automatically.
- mode  in  2  pattern: 0 solid, 1 stripes, 2 checker, 3 colour bars.
- fg_color  in  24  foreground RGB.
- bg_color  in  24  background RGB.
- busy  out  1  high from frame launch until frame_done.
- frame_done  out  1  one-cycle pulse after last pixel acked.
- wshb_cyc  out  1  bus cycle; always equal to wshb_stb.
- wshb_stb  out  1  strobe.
- wshb_we  out  1  constant 1.
- wshb_sel  out  4  constant 4'b1111.
- wshb_cti  out  3  constant 0 (classic cycles).
- wshb_bte  out  2  constant 0.
- wshb_adr  out  ADDR_W  byte address.
- wshb_dat_ms  out  32  pixel data {8'h00, RGB}.
- wshb_ack  in  1  slave acknowledge.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state IDLE; x, y, pixel and burst counters = 0.
  - stb/cyc = 0, busy = 0, frame_done = 0, adr = BASE_ADDR, dat_ms = 0.
  - Reset mid-burst drops stb on that edge; no further writes until the next start.
- FSM states: IDLE, BURST, GAP, DONE.
  - IDLE, start=1:
    - latch mode, fg_color and bg_color for the whole frame.
    - clear counters; busy <= 1; go to BURST.
  - BURST: stb = 1; adr and dat_ms held stable until the cycle ack=1 is sampled.
    - On each ack:
      - pixel index + 1; adr + 4.
      - x + 1, wrapping to 0 at HDISP-1 with y + 1.
      - dat_ms for the new pixel is valid on the next cycle.
      - burst count + 1.
    - Ack on the last pixel (index HDISP*VDISP-1) -> DONE.
    - Else ack completing BURST acks -> GAP.
  - GAP: stb = 0 for exactly one cycle; burst count cleared; -> BURST.
  - DONE:
    - stb = 0; frame_done = 1 for this cycle only; adr <= BASE_ADDR.
    - continuous=1: relatch mode/colours, clear counters, -> BURST; busy stays 1.
    - continuous=0: busy <= 0 on leaving DONE; -> IDLE.
- ack outside BURST: ignored.
- start while busy: ignored. start and continuous=1 in DONE: single relaunch only.
- Address = BASE_ADDR + 4*(y*HDISP + x); the multiply is realised by the incrementing pointer, not by a multiplier.
- Pixel colour, computed from the current (x, y):
  - mode 0: fg.
  - mode 1: fg if x mod 4 == 0, else bg.
  - mode 2: fg if (x[3] xor y[3]) == 1, else bg (8x8 cells).
  - mode 3: bar index b = floor(x / (HDISP/8)), clamped to 7. Tracked with a bar-width counter, no divider. Palette by b:
    - 0 FFFFFF, 1 FFFF00, 2 00FFFF, 3 00FF00
    - 4 FF00FF, 5 FF0000, 6 0000FF, 7 000000
- Counter widths: $clog2(HDISP*VDISP) for the pixel count, $clog2(HDISP) for x, $clog2(VDISP) for y, $clog2(BURST+1) for the burst count.
- A partial final burst (frame size not a multiple of BURST) ends at the last pixel and goes straight to DONE.

Test Plan:
- Reset, then start with mode 0, fg=0x123456, ack always high, HDISP=16, VDISP=4, BURST=8 -> first write at adr=BASE_ADDR, dat=0x00123456. stb high for 8 cycles, low 1 cycle, repeated 8 times. frame_done pulses once after the 64th ack; last adr = BASE_ADDR+252; busy then 0.
- Mode 1, fg=FFFFFF, bg=000000, random ack stalls -> adr/dat stable while ack=0. Pixel x=0,4,8 = FFFFFF; x=1..3 = 0. No address skipped or repeated across 64 writes.
- Mode 3, HDISP=16 -> pixels x=0..1 FFFFFF, x=2..3 FFFF00, ..., x=14..15 000000, per line.
- Mode 2, HDISP=32, VDISP=16 -> pixel (8,0)=fg, (0,8)=fg, (8,8)=bg, (0,0)=bg.
- continuous=1 with start, then mode changed mid-frame -> frame 1 uses the old mode. frame_done pulses and the second frame restarts at BASE_ADDR with the new mode; busy never drops. start pulses mid-frame are ignored.
- rst_n low for 1 cycle mid-burst after 5 acks -> stb=0 and adr=BASE_ADDR next cycle, busy=0. A fresh start rewrites from pixel 0.
